// File: rtl/conv2_output_stage.sv
// Output stage of conv layer 2: bias add, rescale, clamp and feature-map addressing.
// Define CONV2_RELU_EN to clamp to the unsigned ReLU range instead of the signed range.
module conv2_output_stage #(
   parameter int OUT_ROWS = 8,
   parameter int OUT_COLS = 8,
   parameter int OUT_W    = 8,
   parameter int SHIFT    = 4,
   parameter int ADDR_W   = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [17:0]       bias,
   input  logic [17:0]       in_data,
   input  logic              in_valid,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_addr,
   output logic              busy,
   output logic              frame_done,
   output logic              sat_flag
);

   localparam int ROW_W = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
   localparam int COL_W = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;

`ifdef CONV2_RELU_EN
   localparam logic signed [31:0] CLAMP_HI = (32'sd1 <<< OUT_W) - 32'sd1;
`else
   localparam logic signed [31:0] CLAMP_HI = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
   localparam logic signed [31:0] CLAMP_LO = -(32'sd1 <<< (OUT_W - 1));
`endif

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t              state;
   state_t              next_state;
   logic [ROW_W-1:0]    row;
   logic [COL_W-1:0]    col;
   logic signed [17:0]  bias_q;
   logic                s1_valid;
   logic signed [18:0]  s1_sum;
   logic [ADDR_W-1:0]   s1_addr;
   logic                start_ok;
   logic                accept;
   logic                last_sample;
   logic [ADDR_W-1:0]   cur_addr;
   logic signed [18:0]  shifted;
   logic signed [31:0]  scaled;
   logic [OUT_W-1:0]    clamp_data;
   logic                clamp_sat;

   assign start_ok    = (state == IDLE) && start;
   assign accept      = (state == RUN) && in_valid;
   assign last_sample = accept && (row == ROW_W'(OUT_ROWS - 1)) && (col == COL_W'(OUT_COLS - 1));
   assign cur_addr    = ADDR_W'(row) * ADDR_W'(OUT_COLS) + ADDR_W'(col);
   assign busy        = (state == RUN) || (state == FLUSH);
   assign frame_done  = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // FLUSH only needs stage 1 drained: the last sample is then on the outputs,
   // so DONE lands exactly one cycle after the final out_valid.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = RUN;
         RUN:     if (last_sample) next_state = FLUSH;
         FLUSH:   if (!s1_valid) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row    <= '0;
         col    <= '0;
         bias_q <= '0;
      end else if (start_ok) begin
         row    <= '0;
         col    <= '0;
         bias_q <= bias;
      end else if (accept) begin
         if (col == COL_W'(OUT_COLS - 1)) begin
            col <= '0;
            row <= (row == ROW_W'(OUT_ROWS - 1)) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Stage 1: 19-bit sum of two sign-extended 18-bit operands cannot overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sum   <= '0;
         s1_addr  <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_sum  <= {in_data[17], in_data} + {bias_q[17], bias_q};
            s1_addr <= cur_addr;
         end
      end
   end

   always_comb begin
      shifted    = s1_sum >>> SHIFT;
      scaled     = {{13{shifted[18]}}, shifted};
      clamp_data = OUT_W'(scaled);
      clamp_sat  = 1'b0;
`ifdef CONV2_RELU_EN
      if (scaled < 32'sd0) begin
         clamp_data = '0;
      end else if (scaled > CLAMP_HI) begin
         clamp_data = OUT_W'(CLAMP_HI);
         clamp_sat  = 1'b1;
      end
`else
      if (scaled > CLAMP_HI) begin
         clamp_data = OUT_W'(CLAMP_HI);
         clamp_sat  = 1'b1;
      end else if (scaled < CLAMP_LO) begin
         clamp_data = OUT_W'(CLAMP_LO);
         clamp_sat  = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_addr  <= '0;
         sat_flag  <= 1'b0;
      end else begin
         out_valid <= s1_valid;
         out_data  <= s1_valid ? clamp_data : '0;
         out_addr  <= s1_valid ? s1_addr : '0;
         if (start_ok) begin
            sat_flag <= 1'b0;
         end else if (s1_valid && clamp_sat) begin
            sat_flag <= 1'b1;
         end
      end
   end

endmodule
